// File: rtl/lifo_stack.sv
// lifo_stack -- parameterized LIFO stack with registered pop data.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   init          synchronous clear (count/errors/valid), highest priority after reset
//   push, pop     requests sampled on the rising edge of clk
//   data_in       word to push
//   data_out      registered popped word, holds between accepted pops
//   data_valid    one-cycle pulse when data_out was updated by an accepted pop
//   top           combinational peek of mem[count-1], zero when empty
//   count         occupancy 0..DEPTH (also the stack pointer)
//   full, empty, almost_full    decodes of count
//   overflow_err, underflow_err sticky until reset or init
module lifo_stack #(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow_err,
  output logic                     underflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr;
  logic          do_repl, do_push, do_pop, push_drop, pop_drop, wr_en;

  // Low AW bits of count minus one wraps to DEPTH-1 when count==DEPTH,
  // which is exactly the top slot of a full stack.
  assign rd_ptr = count[AW-1:0] - AW'(1);

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign top         = empty ? '0 : mem[rd_ptr];

  // Push+pop on a non-empty stack replaces the top (also when full);
  // on an empty stack it degrades to a plain push.
  assign do_repl   = push && pop && !empty;
  assign do_push   = push && (!pop || empty) && !full;
  assign push_drop = push && !pop && full;
  assign do_pop    = pop && !push && !empty;
  assign pop_drop  = pop && !push && empty;

  assign wr_en   = rst && !init && (do_repl || do_push);
  assign wr_addr = do_repl ? rd_ptr : count[AW-1:0];

  // Storage is not reset; entries at or above count are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (init) begin
      count         <= '0;
      data_valid    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (do_repl) begin
        data_out   <= top;
        data_valid <= 1'b1;
      end else if (do_push) begin
        count <= count + CW'(1);
      end else if (do_pop) begin
        data_out   <= top;
        data_valid <= 1'b1;
        count      <= count - CW'(1);
      end
      if (push_drop) overflow_err  <= 1'b1;
      if (pop_drop)  underflow_err <= 1'b1;
    end
  end
endmodule
